// File: rtl/simon_ctrl_pkg.sv
// simon_ctrl_pkg
// Shared definitions for the SIMON command sequencer: the FSM state
// encoding, host command bytes, the reply bytes and the byte-lane
// helpers. Both the key and the text use the same mapping, with byte b
// at bits [8b+7:8b], so word i is {byte 2i+1, byte 2i}.
package simon_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_KEY  = 3'd1,
        ST_GET_TEXT = 3'd2,
        ST_RUN      = 3'd3,
        ST_SEND     = 3'd4,
        ST_REPLY    = 3'd5
    } state_e;

    localparam logic [7:0] CMD_KEY  = 8'h4B;
    localparam logic [7:0] CMD_ENC  = 8'h45;
    localparam logic [7:0] CMD_DEC  = 8'h44;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // Byte/word mapping: byte b sits at bit offset BYTE_W*b.
    localparam int unsigned BYTE_W        = 8;
    localparam logic [2:0]  KEY_LAST_IDX  = 3'd7;
    localparam logic [2:0]  TEXT_LAST_IDX = 3'd3;
    localparam logic [2:0]  REPLY_LEN     = 3'd1;
    localparam logic [2:0]  RESULT_LEN    = 3'd4;

    // Place byte idx of the 64-bit key.
    function automatic logic [63:0] put_key_byte(input logic [63:0] v,
                                                 input logic [2:0]  idx,
                                                 input logic [7:0]  b);
        logic [63:0] r;
        r = v;
        r[BYTE_W*idx +: BYTE_W] = b;
        return r;
    endfunction

    // Place byte idx of the 32-bit text block.
    function automatic logic [31:0] put_text_byte(input logic [31:0] v,
                                                  input logic [1:0]  idx,
                                                  input logic [7:0]  b);
        logic [31:0] r;
        r = v;
        r[BYTE_W*idx +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/tx_byte_sender.sv
// tx_byte_sender
// Holds up to four bytes (byte 0 in data_i[7:0]) and hands them one at a
// time to the UART transmitter. A byte is issued only when the
// transmitter is idle and the previous byte has been acknowledged by
// tx_done_i. empty_o is high when nothing is queued or outstanding.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   load_i        one-cycle pulse: accept data_i / count_i
//   data_i        bytes to send, byte 0 first
//   count_i       number of bytes to send (1..4)
//   tx_active_i   transmitter busy
//   tx_done_i     one-cycle pulse, byte sent
//   tx_dv_o       one-cycle pulse, tx_byte_o valid
//   tx_byte_o     byte to transmit, held until the next issue
//   empty_o       queue empty and no byte outstanding
module tx_byte_sender
    import simon_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  count_i,
    input  logic        tx_active_i,
    input  logic        tx_done_i,
    output logic        tx_dv_o,
    output logic [7:0]  tx_byte_o,
    output logic        empty_o
);

    logic [31:0] buf_q,     buf_d;
    logic [2:0]  remain_q,  remain_d;
    logic        pend_q,    pend_d;
    logic        tx_dv_q,   tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        empty_q,   empty_d;

    // Next-state: load, retire on tx_done_i, issue the next byte.
    always_comb begin
        buf_d     = buf_q;
        remain_d  = remain_q;
        pend_d    = pend_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;

        if (tx_done_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (load_i) begin
            buf_d    = data_i;
            remain_d = count_i;
        end else if ((remain_q != 3'd0) && !pend_q && !tx_active_i) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = buf_q[BYTE_W-1:0];
            buf_d     = {8'h00, buf_q[31:BYTE_W]};
            remain_d  = remain_q - 3'd1;
            pend_d    = 1'b1;
        end else begin
            buf_d = buf_q;
        end

        empty_d = (remain_d == 3'd0) && !pend_d;
    end

    // Sender registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q     <= 32'h0000_0000;
            remain_q  <= 3'd0;
            pend_q    <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            empty_q   <= 1'b1;
        end else begin
            buf_q     <= buf_d;
            remain_q  <= remain_d;
            pend_q    <= pend_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            empty_q   <= empty_d;
        end
    end

    assign tx_dv_o   = tx_dv_q;
    assign tx_byte_o = tx_byte_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/simon_cmd_sequencer.sv
// simon_cmd_sequencer
// Parses host commands from UART bytes, assembles key and text blocks,
// runs the SIMON 32/64 core and returns the 4-byte result or ACK/NAK.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   rx_dv_i/rx_byte_i  received byte strobe and data
//   tx_dv_o/tx_byte_o  byte to transmit (via tx_byte_sender)
//   tx_active_i        transmitter busy
//   tx_done_i          byte sent pulse
//   simon_run_o        core run request, high while computing
//   cryp_decryp_o      0 = encrypt, 1 = decrypt
//   key_o, text_o      committed key and text block
//   simon_done_i       core result valid
//   crypt_i            core result
//   state_o            current FSM state (status LEDs)
//   key_valid_o        a complete key has been committed
//   overrun_o          sticky: a byte was dropped while busy
module simon_cmd_sequencer
    import simon_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_dv_i,
    input  logic [7:0]  rx_byte_i,
    output logic        tx_dv_o,
    output logic [7:0]  tx_byte_o,
    input  logic        tx_active_i,
    input  logic        tx_done_i,
    output logic        simon_run_o,
    output logic        cryp_decryp_o,
    output logic [63:0] key_o,
    output logic [31:0] text_o,
    input  logic        simon_done_i,
    input  logic [31:0] crypt_i,
    output logic [2:0]  state_o,
    output logic        key_valid_o,
    output logic        overrun_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q,     state_d;
    logic [2:0]       idx_q,       idx_d;
    logic [63:0]      shadow_q,    shadow_d;
    logic [63:0]      key_q,       key_d;
    logic             key_valid_q, key_valid_d;
    logic [31:0]      text_q,      text_d;
    logic             cryp_q,      cryp_d;
    logic             run_q,       run_d;
    logic             overrun_q,   overrun_d;
    logic [CNT_W-1:0] tocnt_q,     tocnt_d;

    logic        snd_load_s;
    logic [31:0] snd_data_s;
    logic [2:0]  snd_count_s;
    logic        snd_empty_s;
    logic        timeout_s;

    // Expiry is evaluated on the TIMEOUT_CYCLES-th idle cycle; a byte
    // arriving in that same cycle takes priority.
    assign timeout_s = (tocnt_q == CNT_LAST);

    // Command FSM next-state and datapath.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        text_d      = text_q;
        cryp_d      = cryp_q;
        run_d       = run_q;
        overrun_d   = overrun_q;
        tocnt_d     = tocnt_q;
        snd_load_s  = 1'b0;
        snd_data_s  = 32'h0000_0000;
        snd_count_s = 3'd0;

        case (state_q)
            ST_IDLE: begin
                tocnt_d = CNT_ZERO;
                if (rx_dv_i) begin
                    if (rx_byte_i == CMD_KEY) begin
                        idx_d     = 3'd0;
                        overrun_d = 1'b0;
                        state_d   = ST_GET_KEY;
                    end else if ((rx_byte_i == CMD_ENC) || (rx_byte_i == CMD_DEC)) begin
                        cryp_d    = (rx_byte_i == CMD_DEC);
                        overrun_d = 1'b0;
                        idx_d     = 3'd0;
                        if (key_valid_q) begin
                            state_d = ST_GET_TEXT;
                        end else begin
                            snd_load_s  = 1'b1;
                            snd_data_s  = {24'h000000, NAK_BYTE};
                            snd_count_s = REPLY_LEN;
                            state_d     = ST_REPLY;
                        end
                    end else begin
                        snd_load_s  = 1'b1;
                        snd_data_s  = {24'h000000, NAK_BYTE};
                        snd_count_s = REPLY_LEN;
                        state_d     = ST_REPLY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GET_KEY: begin
                if (rx_dv_i) begin
                    tocnt_d  = CNT_ZERO;
                    shadow_d = put_key_byte(shadow_q, idx_q, rx_byte_i);
                    if (idx_q == KEY_LAST_IDX) begin
                        // Commit only a complete key.
                        key_d       = shadow_d;
                        key_valid_d = 1'b1;
                        idx_d       = 3'd0;
                        snd_load_s  = 1'b1;
                        snd_data_s  = {24'h000000, ACK_BYTE};
                        snd_count_s = REPLY_LEN;
                        state_d     = ST_REPLY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (timeout_s) begin
                    idx_d       = 3'd0;
                    snd_load_s  = 1'b1;
                    snd_data_s  = {24'h000000, NAK_BYTE};
                    snd_count_s = REPLY_LEN;
                    state_d     = ST_REPLY;
                end else begin
                    tocnt_d = tocnt_q + CNT_ONE;
                end
            end

            ST_GET_TEXT: begin
                if (rx_dv_i) begin
                    tocnt_d = CNT_ZERO;
                    text_d  = put_text_byte(text_q, idx_q[1:0], rx_byte_i);
                    if (idx_q == TEXT_LAST_IDX) begin
                        idx_d   = 3'd0;
                        run_d   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (timeout_s) begin
                    idx_d       = 3'd0;
                    snd_load_s  = 1'b1;
                    snd_data_s  = {24'h000000, NAK_BYTE};
                    snd_count_s = REPLY_LEN;
                    state_d     = ST_REPLY;
                end else begin
                    tocnt_d = tocnt_q + CNT_ONE;
                end
            end

            ST_RUN: begin
                if (rx_dv_i) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                // The sender buffer acts as the result register.
                if (simon_done_i) begin
                    run_d       = 1'b0;
                    snd_load_s  = 1'b1;
                    snd_data_s  = crypt_i;
                    snd_count_s = RESULT_LEN;
                    state_d     = ST_SEND;
                end else begin
                    run_d = 1'b1;
                end
            end

            ST_SEND, ST_REPLY: begin
                if (rx_dv_i) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (snd_empty_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end

            default: begin
                run_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            shadow_q    <= 64'h0;
            key_q       <= 64'h0;
            key_valid_q <= 1'b0;
            text_q      <= 32'h0;
            cryp_q      <= 1'b0;
            run_q       <= 1'b0;
            overrun_q   <= 1'b0;
            tocnt_q     <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            text_q      <= text_d;
            cryp_q      <= cryp_d;
            run_q       <= run_d;
            overrun_q   <= overrun_d;
            tocnt_q     <= tocnt_d;
        end
    end

    tx_byte_sender u_sender (
        .clk         (clk),
        .resetn      (resetn),
        .load_i      (snd_load_s),
        .data_i      (snd_data_s),
        .count_i     (snd_count_s),
        .tx_active_i (tx_active_i),
        .tx_done_i   (tx_done_i),
        .tx_dv_o     (tx_dv_o),
        .tx_byte_o   (tx_byte_o),
        .empty_o     (snd_empty_s)
    );

    assign state_o       = state_q;
    assign simon_run_o   = run_q;
    assign cryp_decryp_o = cryp_q;
    assign key_o         = key_q;
    assign text_o        = text_q;
    assign key_valid_o   = key_valid_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_simon_cmd_sequencer.sv
module tb_simon_cmd_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic        simon_run;
    logic        cryp_decryp;
    logic [63:0] key;
    logic [31:0] text;
    logic        simon_done;
    logic [31:0] crypt;
    logic [2:0]  state;
    logic        key_valid;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] tx_log [0:255];
    int         tx_cnt;
    int         busy_cnt;
    int         run_cnt;

    always #5 clk = ~clk;

    simon_cmd_sequencer #(.TIMEOUT_CYCLES(1000)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rx_dv_i       (rx_dv),
        .rx_byte_i     (rx_byte),
        .tx_dv_o       (tx_dv),
        .tx_byte_o     (tx_byte),
        .tx_active_i   (tx_active),
        .tx_done_i     (tx_done),
        .simon_run_o   (simon_run),
        .cryp_decryp_o (cryp_decryp),
        .key_o         (key),
        .text_o        (text),
        .simon_done_i  (simon_done),
        .crypt_i       (crypt),
        .state_o       (state),
        .key_valid_o   (key_valid),
        .overrun_o     (overrun)
    );

    // UART transmitter model: logs each byte, busy 3 cycles, then tx_done.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            busy_cnt  <= 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_dv) begin
                tx_log[tx_cnt[7:0]] <= tx_byte;
                tx_cnt    <= tx_cnt + 1;
                tx_active <= 1'b1;
                busy_cnt  <= 3;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    tx_done   <= 1'b1;
                    tx_active <= 1'b0;
                end
            end
        end
    end

    initial tx_cnt = 0;

    // Core stub: result valid on the 32nd cycle of simon_run_o.
    always @(posedge clk) begin
        run_cnt <= simon_run ? run_cnt + 1 : 0;
    end
    initial run_cnt = 0;
    assign simon_done = simon_run && (run_cnt == 31);
    assign crypt      = 32'hC69BE9BB;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while (state != 3'd0 && g < 300) begin
            tick();
            g++;
        end
        check(name, {61'h0, state}, 64'h0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [2:0] st;
        logic       kv;
        logic       rep;
        logic [7:0] reply;
    } vec_t;

    vec_t vecs [0:10];

    int base;
    int runs;
    int g;
    logic tx_seen;

    initial begin
        vecs[0]  = '{8'h44, 3'd5, 1'b0, 1'b1, 8'h15};   // D without key
        vecs[1]  = '{8'h5A, 3'd5, 1'b0, 1'b1, 8'h15};   // unknown byte
        vecs[2]  = '{8'h4B, 3'd1, 1'b0, 1'b0, 8'h00};   // K
        vecs[3]  = '{8'h00, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{8'h01, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{8'h08, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{8'h09, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{8'h10, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{8'h11, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{8'h18, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{8'h19, 3'd5, 1'b1, 1'b1, 8'h06};

        resetn  = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Reset values
        check("rst_state", {61'h0, state}, 64'h0);
        check("rst_flags", {58'h0, tx_dv, simon_run, cryp_decryp, key_valid, overrun, 1'b0}, 64'h0);
        check("rst_tx_byte", {56'h0, tx_byte}, 64'h0);
        check("rst_key", key, 64'h0);
        check("rst_text", {32'h0, text}, 64'h0);

        // Table: NAK cases and key load
        for (int i = 0; i < 11; i++) begin
            base = tx_cnt;
            send_byte(vecs[i].b);
            check($sformatf("vec%0d_state", i), {61'h0, state}, {61'h0, vecs[i].st});
            check($sformatf("vec%0d_kv", i), {63'h0, key_valid}, {63'h0, vecs[i].kv});
            if (vecs[i].rep) begin
                wait_idle($sformatf("vec%0d_idle", i));
                check($sformatf("vec%0d_txcnt", i), 64'(tx_cnt - base), 64'd1);
                check($sformatf("vec%0d_reply", i), {56'h0, tx_log[base[7:0]]}, {56'h0, vecs[i].reply});
            end
        end
        check("key_loaded", key, 64'h1918_1110_0908_0100);

        // Encrypt: text assembly, run length, result stream
        base = tx_cnt;
        send_byte(8'h45);
        check("enc_state", {61'h0, state}, 64'd2);
        send_byte(8'h77);
        send_byte(8'h68);
        send_byte(8'h65);
        send_byte(8'h65);
        check("enc_run_rise", {62'h0, state == 3'd3, simon_run}, 64'h3);
        check("enc_text", {32'h0, text}, 64'h6565_6877);
        check("enc_cryp", {63'h0, cryp_decryp}, 64'h0);
        runs = 0;
        while (simon_run && runs < 200) begin
            runs++;
            tick();
        end
        check("enc_run_cycles", 64'(runs), 64'd32);
        check("enc_dv_gap", {63'h0, tx_dv}, 64'h0);
        tick();
        check("enc_dv_first", {55'h0, tx_dv, tx_byte}, {55'h0, 1'b1, 8'hBB});
        wait_idle("enc_idle");
        check("enc_txcnt", 64'(tx_cnt - base), 64'd4);
        check("enc_bytes", {32'h0, tx_log[base[7:0]], tx_log[8'(base + 1)], tx_log[8'(base + 2)], tx_log[8'(base + 3)]},
              {32'h0, 32'hBBE9_9BC6});

        // Decrypt with bytes injected during RUN
        base = tx_cnt;
        send_byte(8'h44);
        check("dec_cryp", {63'h0, cryp_decryp}, 64'h1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("dec_text", {32'h0, text}, 64'h0403_0201);
        repeat (5) tick();
        send_byte(8'hAA);
        send_byte(8'h4B);
        check("dec_ovr_state", {61'h0, state}, 64'd3);
        wait_idle("dec_idle");
        check("dec_overrun", {63'h0, overrun}, 64'h1);
        check("dec_txcnt", 64'(tx_cnt - base), 64'd4);
        check("dec_bytes", {32'h0, tx_log[base[7:0]], tx_log[8'(base + 1)], tx_log[8'(base + 2)], tx_log[8'(base + 3)]},
              {32'h0, 32'hBBE9_9BC6});

        // Timeout after partial key; K also clears overrun
        base = tx_cnt;
        send_byte(8'h4B);
        check("to_ovr_clear", {63'h0, overrun}, 64'h0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        repeat (999) tick();
        check("to_not_yet", {61'h0, state}, 64'd1);
        tick();
        check("to_expired", {61'h0, state}, 64'd5);
        wait_idle("to_idle");
        check("to_reply", {56'h0, tx_log[base[7:0]]}, 64'h15);
        check("to_key", key, 64'h1918_1110_0908_0100);
        check("to_kv", {63'h0, key_valid}, 64'h1);

        // Byte on the last timeout cycle is accepted
        base = tx_cnt;
        send_byte(8'h4B);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (999) tick();
        send_byte(8'h44);
        check("edge_state", {61'h0, state}, 64'd1);
        check("edge_no_tx", 64'(tx_cnt - base), 64'd0);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        wait_idle("edge_idle");
        check("edge_key", key, 64'h8877_6655_4433_2211);
        check("edge_ack", {56'h0, tx_log[base[7:0]]}, 64'h06);

        // Reset during SEND
        send_byte(8'h45);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        g = 0;
        while (!tx_dv && g < 200) begin
            tick();
            g++;
        end
        check("rs_in_send", {61'h0, state}, 64'd4);
        resetn = 1'b0;
        #1;
        check("rs_state", {61'h0, state}, 64'h0);
        check("rs_kv", {63'h0, key_valid}, 64'h0);
        tick();
        resetn = 1'b1;
        tx_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            tx_seen = tx_seen | tx_dv;
        end
        check("rs_tx_quiet", {63'h0, tx_seen}, 64'h0);
        check("rs_state_after", {61'h0, state}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_cmd_sequencer.md
# simon_cmd_sequencer

Command sequencer between the UART byte link and the SIMON 32/64 core. It parses host commands from received bytes and assembles the 64-bit key and 32-bit text blocks. It launches the core with a run/done handshake and streams the 4-byte result or an ACK/NAK back through the UART transmitter. It owns key retention and the inter-byte timeout, and replaces the ad-hoc command FSM at top level.

## Interface
- TIMEOUT_CYCLES, 100_000_000: maximum idle cycles between bytes of one command (1 s at 100 MHz).
- CMD_KEY, 8'h4B: load-key command ('K').
- CMD_ENC, 8'h45: encrypt command ('E').
- CMD_DEC, 8'h44: decrypt command ('D').
- clk  in  1  system clock.
- resetn  in  1  reset; one clock, reset is asynchronous and active-low.
- rx_dv_i  in  1  one-cycle pulse, received byte valid.
- rx_byte_i  in  8  received byte.
- tx_dv_o  out  1  one-cycle pulse, send tx_byte_o.
- tx_byte_o  out  8  byte to transmit, held until tx_done_i.
- tx_active_i  in  1  transmitter busy.
- tx_done_i  in  1  one-cycle pulse, byte sent.
- simon_run_o  out  1  high while the core computes.
- cryp_decryp_o  out  1  0 = encrypt, 1 = decrypt.
- key_o  out  64  key; word i = key_o[16i+15:16i] = {byte 2i+1, byte 2i}.
- text_o  out  32  text block; same byte/word mapping.
- simon_done_i  in  1  core result valid.
- crypt_i  in  32  core result, same mapping.
- state_o  out  3  current state encoding, drives status LEDs.
- key_valid_o  out  1  a complete key has been committed.
- overrun_o  out  1  sticky flag: a byte was dropped while busy.

## Operation
- States: IDLE=0, GET_KEY=1, GET_TEXT=2, RUN=3, SEND=4, REPLY=5.
- IDLE, byte = CMD_KEY: clear the byte index, clear overrun_o, go to GET_KEY.
- IDLE, byte = CMD_ENC or CMD_DEC:
  - Latch cryp_decryp_o and clear overrun_o.
  - With key_valid_o = 1, go to GET_TEXT.
  - Otherwise reply NAK 8'h15.
- IDLE, any other byte: reply NAK.
- GET_KEY:
  - Bytes 0..7 go into a shadow buffer, first byte is byte 0.
  - After byte 7, copy the shadow to key_o, set key_valid_o, and reply ACK 8'h06.
  - A partial key never alters key_o.
- GET_TEXT: bytes 0..3 go into text_o. After byte 3, go to RUN.
- RUN:
  - simon_run_o = 1 until the cycle simon_done_i = 1.
  - On that cycle, capture crypt_i into the result register and drop simon_run_o.
  - Go to SEND; simon_run_o stays low for at least 1 cycle.
- SEND: transmit result bytes 0,1,2,3 in order, then go to IDLE.
- REPLY: transmit one reply byte, then go to IDLE.
- TX rule:
  - Pulse tx_dv_o only when tx_active_i = 0 and no byte is outstanding.
  - The next byte is issued only after tx_done_i.
- Timeout:
  - A counter runs in GET_KEY and GET_TEXT and resets on every rx_dv_i.
  - When it reaches TIMEOUT_CYCLES, discard partial data and reply NAK.
  - If rx_dv_i and expiry occur in the same cycle, the byte wins.
  - key_valid_o and key_o are unchanged by a timeout.
- Bytes received in RUN, SEND or REPLY are dropped and set overrun_o.

## Timing
- Reset values:
  - state IDLE.
  - tx_dv_o, tx_byte_o, simon_run_o, cryp_decryp_o, key_valid_o and overrun_o all 0.
  - key_o = 0, text_o = 0.
- Byte accept: the register updates on the clk edge after the rx_dv_i cycle.
- GET_TEXT to RUN: simon_run_o rises 1 cycle after the 4th text byte.
- done to first tx_dv_o: 2 cycles (capture, then issue) when tx_active_i = 0.
- Reply and result bytes: gap is 1 cycle after each tx_done_i.
- Reset assertion mid-command aborts immediately.
- Reset clears key_valid_o, and any in-flight byte is abandoned.

## Structure
- Package simon_ctrl_pkg holds:
  - the state enum (3-bit);
  - the command constants;
  - ACK 8'h06 and NAK 8'h15;
  - the byte/word mapping localparams.
- Sub-module tx_byte_sender:
  - Queues up to 4 bytes and issues them with the tx_dv_o/tx_done_i handshake.
  - Raises empty when all bytes are sent.
  - Shared by SEND and REPLY.

## Test plan
- K, 00 01 08 09 10 11 18 19 -> key_o = 64'h1918_1110_0908_0100, key_valid_o = 1, one tx byte 06.
- E, 77 68 65 65 with core stub returning crypt_i = 32'hC69BE9BB after 32 cycles:
  - text_o = 32'h6565_6877, cryp_decryp_o = 0;
  - simon_run_o high 32 cycles;
  - tx bytes BB E9 9B C6.
- D after reset with no key, and byte 8'h5A -> each replies single NAK 15, state returns to 0.
- K, 3 bytes, then silence of TIMEOUT_CYCLES (set to 1000) -> NAK 15, key_o and key_valid_o unchanged.
- Byte at exactly cycle 1000 of the timeout -> no NAK, collection continues.
- Bytes injected during RUN -> overrun_o = 1, result unaffected; next command clears overrun_o.
- Reset asserted mid-SEND -> tx_dv_o stays 0, state 0, key_valid_o = 0.
